eeg_oram_bank_router: RTL and testbench

- Parametrised, registered successor to the per-channel ORAM demux.
- Each of ORAM_NUM_DW output-RAM channels carries a write stream (addr+data), a read-address stream and a read-return stream.
- Write and read-address requests are steered to one of OMUX_NUM_DW banks by the top address bits, through a one-deep output register per channel and stream.
- Read returns are merged back in request order using a per-channel bank-tag FIFO. This removes the old "no collision" assumption and the AND-of-all-ready coupling between banks.

---
 rtl/eeg_oram_pkg.sv | 44 ++++
 rtl/eeg_oram_bank_router_if.sv | 65 ++++++
 rtl/eeg_oram_tag_fifo.sv | 61 ++++++
 rtl/eeg_oram_bank_router.sv | 114 +++++++++++
 tb/tb_eeg_oram_bank_router.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/eeg_oram_pkg.sv
// Shared configuration, slot payload types and address-split helpers for the ORAM bank router.
package eeg_oram_pkg;

    localparam int unsigned ORAM_NUM_DW = 4;
    localparam int unsigned OMUX_NUM_DW = 4;
    localparam int unsigned OMUX_NUM_AW = $clog2(OMUX_NUM_DW);
    localparam int unsigned ORAM_ADD_AW = 12;
    localparam int unsigned OMUX_ADD_AW = 10;
    localparam int unsigned ORAM_DAT_DW = 4;
    localparam int unsigned TAG_DEPTH   = 4;
    localparam int unsigned CNT_AW      = $clog2(TAG_DEPTH + 1);

    typedef logic [OMUX_NUM_AW-1:0] bank_t;
    typedef logic [OMUX_ADD_AW-1:0] ladd_t;
    typedef logic [ORAM_DAT_DW-1:0] dat_t;

    // Write slot payload.
    typedef struct packed {
        logic  vld;
        logic  lst;
        bank_t bank;
        ladd_t add;
        dat_t  dat;
    } slot_t;

    // Read-address slot payload; it carries no data.
    typedef struct packed {
        logic  vld;
        logic  lst;
        bank_t bank;
        ladd_t add;
    } rd_slot_t;

    // Bank index taken from the top address bits.
    function automatic bank_t bank_of(input logic [ORAM_ADD_AW-1:0] addr);
        return addr[ORAM_ADD_AW-1 -: OMUX_NUM_AW];
    endfunction

    // Bank-local address taken from the low address bits.
    function automatic ladd_t local_of(input logic [ORAM_ADD_AW-1:0] addr);
        return addr[OMUX_ADD_AW-1:0];
    endfunction

endpackage

// File: rtl/eeg_oram_bank_router_if.sv
// Upstream channel streams and per-bank streams of the ORAM bank router.
interface eeg_oram_bank_router_if;
    import eeg_oram_pkg::*;

    logic [ORAM_NUM_DW-1:0]                  MUX_MTOO_DAT_VLD;
    logic [ORAM_NUM_DW-1:0]                  MUX_MTOO_DAT_LST;
    logic [ORAM_NUM_DW-1:0]                  MUX_MTOO_DAT_RDY;
    logic [ORAM_NUM_DW-1:0][ORAM_ADD_AW-1:0] MUX_MTOO_DAT_ADD;
    logic [ORAM_NUM_DW-1:0][ORAM_DAT_DW-1:0] MUX_MTOO_DAT_DAT;
    logic [ORAM_NUM_DW-1:0]                  MUX_MTOO_ADD_VLD;
    logic [ORAM_NUM_DW-1:0]                  MUX_MTOO_ADD_LST;
    logic [ORAM_NUM_DW-1:0]                  MUX_MTOO_ADD_RDY;
    logic [ORAM_NUM_DW-1:0][ORAM_ADD_AW-1:0] MUX_MTOO_ADD_ADD;
    logic [ORAM_NUM_DW-1:0]                  MUX_OTOM_DAT_VLD;
    logic [ORAM_NUM_DW-1:0]                  MUX_OTOM_DAT_LST;
    logic [ORAM_NUM_DW-1:0]                  MUX_OTOM_DAT_RDY;
    logic [ORAM_NUM_DW-1:0][ORAM_DAT_DW-1:0] MUX_OTOM_DAT_DAT;

    logic [ORAM_NUM_DW-1:0][OMUX_NUM_DW-1:0]                  DMX_MTOO_DAT_VLD;
    logic [ORAM_NUM_DW-1:0][OMUX_NUM_DW-1:0]                  DMX_MTOO_DAT_LST;
    logic [ORAM_NUM_DW-1:0][OMUX_NUM_DW-1:0]                  DMX_MTOO_DAT_RDY;
    logic [ORAM_NUM_DW-1:0][OMUX_NUM_DW-1:0][OMUX_ADD_AW-1:0] DMX_MTOO_DAT_ADD;
    logic [ORAM_NUM_DW-1:0][OMUX_NUM_DW-1:0][ORAM_DAT_DW-1:0] DMX_MTOO_DAT_DAT;
    logic [ORAM_NUM_DW-1:0][OMUX_NUM_DW-1:0]                  DMX_MTOO_ADD_VLD;
    logic [ORAM_NUM_DW-1:0][OMUX_NUM_DW-1:0]                  DMX_MTOO_ADD_LST;
    logic [ORAM_NUM_DW-1:0][OMUX_NUM_DW-1:0]                  DMX_MTOO_ADD_RDY;
    logic [ORAM_NUM_DW-1:0][OMUX_NUM_DW-1:0][OMUX_ADD_AW-1:0] DMX_MTOO_ADD_ADD;
    logic [ORAM_NUM_DW-1:0][OMUX_NUM_DW-1:0]                  DMX_OTOM_DAT_VLD;
    logic [ORAM_NUM_DW-1:0][OMUX_NUM_DW-1:0]                  DMX_OTOM_DAT_LST;
    logic [ORAM_NUM_DW-1:0][OMUX_NUM_DW-1:0]                  DMX_OTOM_DAT_RDY;
    logic [ORAM_NUM_DW-1:0][OMUX_NUM_DW-1:0][ORAM_DAT_DW-1:0] DMX_OTOM_DAT_DAT;

    // Router view.
    modport slave (
        input  MUX_MTOO_DAT_VLD, MUX_MTOO_DAT_LST, MUX_MTOO_DAT_ADD, MUX_MTOO_DAT_DAT,
        output MUX_MTOO_DAT_RDY,
        input  MUX_MTOO_ADD_VLD, MUX_MTOO_ADD_LST, MUX_MTOO_ADD_ADD,
        output MUX_MTOO_ADD_RDY,
        output MUX_OTOM_DAT_VLD, MUX_OTOM_DAT_LST, MUX_OTOM_DAT_DAT,
        input  MUX_OTOM_DAT_RDY,
        output DMX_MTOO_DAT_VLD, DMX_MTOO_DAT_LST, DMX_MTOO_DAT_ADD, DMX_MTOO_DAT_DAT,
        input  DMX_MTOO_DAT_RDY,
        output DMX_MTOO_ADD_VLD, DMX_MTOO_ADD_LST, DMX_MTOO_ADD_ADD,
        input  DMX_MTOO_ADD_RDY,
        input  DMX_OTOM_DAT_VLD, DMX_OTOM_DAT_LST, DMX_OTOM_DAT_DAT,
        output DMX_OTOM_DAT_RDY
    );

    // Environment view: upstream requester plus the banks.
    modport master (
        output MUX_MTOO_DAT_VLD, MUX_MTOO_DAT_LST, MUX_MTOO_DAT_ADD, MUX_MTOO_DAT_DAT,
        input  MUX_MTOO_DAT_RDY,
        output MUX_MTOO_ADD_VLD, MUX_MTOO_ADD_LST, MUX_MTOO_ADD_ADD,
        input  MUX_MTOO_ADD_RDY,
        input  MUX_OTOM_DAT_VLD, MUX_OTOM_DAT_LST, MUX_OTOM_DAT_DAT,
        output MUX_OTOM_DAT_RDY,
        input  DMX_MTOO_DAT_VLD, DMX_MTOO_DAT_LST, DMX_MTOO_DAT_ADD, DMX_MTOO_DAT_DAT,
        output DMX_MTOO_DAT_RDY,
        input  DMX_MTOO_ADD_VLD, DMX_MTOO_ADD_LST, DMX_MTOO_ADD_ADD,
        output DMX_MTOO_ADD_RDY,
        output DMX_OTOM_DAT_VLD, DMX_OTOM_DAT_LST, DMX_OTOM_DAT_DAT,
        input  DMX_OTOM_DAT_RDY
    );

endinterface

// File: rtl/eeg_oram_tag_fifo.sv
// Per-channel FIFO of bank tags for outstanding reads; gives the order in which returns are merged.
module eeg_oram_tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 2,
    parameter int unsigned CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          ne,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push & (cnt_q < CW'(DEPTH));
    assign do_pop  = pop & (cnt_q != '0);
    assign head    = mem[rd_ptr];
    assign ne      = (cnt_q != '0);
    assign count   = cnt_q;

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/eeg_oram_bank_router.sv
// Steers per-channel write and read-address streams to banks through one-deep
// registers and merges read returns back in request order via a bank-tag FIFO.
module eeg_oram_bank_router
    import eeg_oram_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    eeg_oram_bank_router_if.slave               bus,
    output logic [ORAM_NUM_DW-1:0][CNT_AW-1:0]  OUTSTANDING,
    output logic [ORAM_NUM_DW-1:0]              ERR
);

    for (genvar ch = 0; ch < ORAM_NUM_DW; ch++) begin : g_ch
        slot_t         wr_q;
        rd_slot_t      rd_q;
        logic          wr_rdy;
        logic          rd_rdy;
        logic          push;
        logic          pop;
        logic          ne;
        logic          ret_vld;
        logic          err_q;
        bank_t         head;
        logic [CNT_AW-1:0] cnt;

        // Write slot: accept when empty or when its current beat drains this cycle.
        assign wr_rdy = ~wr_q.vld | bus.DMX_MTOO_DAT_RDY[ch][wr_q.bank];
        assign bus.MUX_MTOO_DAT_RDY[ch] = wr_rdy;

        // Write slot register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_q <= '0;
            end else if (bus.MUX_MTOO_DAT_VLD[ch] && wr_rdy) begin
                wr_q.vld  <= 1'b1;
                wr_q.lst  <= bus.MUX_MTOO_DAT_LST[ch];
                wr_q.bank <= bank_of(bus.MUX_MTOO_DAT_ADD[ch]);
                wr_q.add  <= local_of(bus.MUX_MTOO_DAT_ADD[ch]);
                wr_q.dat  <= bus.MUX_MTOO_DAT_DAT[ch];
            end else if (wr_q.vld && bus.DMX_MTOO_DAT_RDY[ch][wr_q.bank]) begin
                wr_q.vld <= 1'b0;
            end
        end

        assign bus.DMX_MTOO_DAT_VLD[ch] = wr_q.vld ? (OMUX_NUM_DW'(1) << wr_q.bank) : '0;

        // Read-address slot: also throttled by free tag space, never by a same-cycle pop.
        assign rd_rdy = (~rd_q.vld | bus.DMX_MTOO_ADD_RDY[ch][rd_q.bank]) & (cnt < CNT_AW'(TAG_DEPTH));
        assign bus.MUX_MTOO_ADD_RDY[ch] = rd_rdy;
        assign push = bus.MUX_MTOO_ADD_VLD[ch] & rd_rdy;

        // Read-address slot register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q <= '0;
            end else if (push) begin
                rd_q.vld  <= 1'b1;
                rd_q.lst  <= bus.MUX_MTOO_ADD_LST[ch];
                rd_q.bank <= bank_of(bus.MUX_MTOO_ADD_ADD[ch]);
                rd_q.add  <= local_of(bus.MUX_MTOO_ADD_ADD[ch]);
            end else if (rd_q.vld && bus.DMX_MTOO_ADD_RDY[ch][rd_q.bank]) begin
                rd_q.vld <= 1'b0;
            end
        end

        assign bus.DMX_MTOO_ADD_VLD[ch] = rd_q.vld ? (OMUX_NUM_DW'(1) << rd_q.bank) : '0;

        // Payload fields are broadcast; only the selected bank sees VLD.
        for (genvar b = 0; b < OMUX_NUM_DW; b++) begin : g_bank
            assign bus.DMX_MTOO_DAT_LST[ch][b] = wr_q.lst;
            assign bus.DMX_MTOO_DAT_ADD[ch][b] = wr_q.add;
            assign bus.DMX_MTOO_DAT_DAT[ch][b] = wr_q.dat;
            assign bus.DMX_MTOO_ADD_LST[ch][b] = rd_q.lst;
            assign bus.DMX_MTOO_ADD_ADD[ch][b] = rd_q.add;
        end

        eeg_oram_tag_fifo #(
            .DEPTH (TAG_DEPTH),
            .W     (OMUX_NUM_AW),
            .CW    (CNT_AW)
        ) u_tag_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push),
            .din   (bank_of(bus.MUX_MTOO_ADD_ADD[ch])),
            .pop   (pop),
            .head  (head),
            .ne    (ne),
            .count (cnt)
        );

        // Return merge: only the bank at the FIFO head may hand a beat upstream.
        assign ret_vld = ne & bus.DMX_OTOM_DAT_VLD[ch][head];
        assign pop     = ret_vld & bus.MUX_OTOM_DAT_RDY[ch];
        assign bus.MUX_OTOM_DAT_VLD[ch] = ret_vld;
        assign bus.MUX_OTOM_DAT_LST[ch] = bus.DMX_OTOM_DAT_LST[ch][head];
        assign bus.MUX_OTOM_DAT_DAT[ch] = bus.DMX_OTOM_DAT_DAT[ch][head];
        assign bus.DMX_OTOM_DAT_RDY[ch] = (ne & bus.MUX_OTOM_DAT_RDY[ch]) ?
                                          (OMUX_NUM_DW'(1) << head) : '0;

        // Sticky flag for a bank return arriving with no read outstanding.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                err_q <= 1'b0;
            end else if (!ne && (bus.DMX_OTOM_DAT_VLD[ch] != '0)) begin
                err_q <= 1'b1;
            end
        end

        assign ERR[ch]         = err_q;
        assign OUTSTANDING[ch] = cnt;
    end

endmodule

// File: tb/tb_eeg_oram_bank_router.sv
// Directed bench for the ORAM bank router: table of write-routing vectors plus
// hand sequences for stall, in-order merge, tag-full, spurious return and reset.
module tb_eeg_oram_bank_router;
    import eeg_oram_pkg::*;

    logic clk;
    logic rst;
    logic [ORAM_NUM_DW-1:0][CNT_AW-1:0] outstanding;
    logic [ORAM_NUM_DW-1:0]             err;

    eeg_oram_bank_router_if bus ();

    eeg_oram_bank_router dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .OUTSTANDING (outstanding),
        .ERR         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         ch;
        logic [11:0] add;
        logic [3:0]  dat;
        logic        lst;
        logic [3:0]  exp_vld;
        logic [9:0]  exp_add;
    } wr_vec_t;

    wr_vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [ORAM_NUM_DW-1:0][OMUX_NUM_DW-1:0] tmp;

    initial begin
        vecs[0] = '{0, 12'hC05, 4'h3, 1'b1, 4'b1000, 10'h005};
        vecs[1] = '{1, 12'h3FF, 4'hF, 1'b0, 4'b0001, 10'h3FF};
        vecs[2] = '{2, 12'h5AB, 4'h9, 1'b1, 4'b0010, 10'h1AB};
        vecs[3] = '{3, 12'h8F0, 4'h6, 1'b0, 4'b0100, 10'h0F0};
        vecs[4] = '{0, 12'h7FF, 4'h1, 1'b0, 4'b0010, 10'h3FF};

        rst = 1'b1;
        bus.MUX_MTOO_DAT_VLD = '0;
        bus.MUX_MTOO_DAT_LST = '0;
        bus.MUX_MTOO_DAT_ADD = '0;
        bus.MUX_MTOO_DAT_DAT = '0;
        bus.MUX_MTOO_ADD_VLD = '0;
        bus.MUX_MTOO_ADD_LST = '0;
        bus.MUX_MTOO_ADD_ADD = '0;
        bus.MUX_OTOM_DAT_RDY = '0;
        bus.DMX_MTOO_DAT_RDY = '1;
        bus.DMX_MTOO_ADD_RDY = '1;
        bus.DMX_OTOM_DAT_VLD = '0;
        bus.DMX_OTOM_DAT_LST = '0;
        bus.DMX_OTOM_DAT_DAT = '0;
        repeat (3) step();
        rst = 1'b0;
        #1;

        // Reset state.
        chk("rst_dat_vld", 64'(bus.DMX_MTOO_DAT_VLD), 64'h0);
        chk("rst_add_vld", 64'(bus.DMX_MTOO_ADD_VLD), 64'h0);
        chk("rst_outstanding", 64'(outstanding), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_wr_rdy", 64'(bus.MUX_MTOO_DAT_RDY), 64'hF);
        chk("rst_rd_rdy", 64'(bus.MUX_MTOO_ADD_RDY), 64'hF);

        // Write routing vectors.
        for (int v = 0; v < 5; v++) begin
            bus.MUX_MTOO_DAT_VLD[vecs[v].ch] = 1'b1;
            bus.MUX_MTOO_DAT_LST[vecs[v].ch] = vecs[v].lst;
            bus.MUX_MTOO_DAT_ADD[vecs[v].ch] = vecs[v].add;
            bus.MUX_MTOO_DAT_DAT[vecs[v].ch] = vecs[v].dat;
            #1;
            chk("vec_up_rdy", 64'(bus.MUX_MTOO_DAT_RDY[vecs[v].ch]), 64'h1);
            step();
            bus.MUX_MTOO_DAT_VLD[vecs[v].ch] = 1'b0;
            #1;
            chk("vec_vld", 64'(bus.DMX_MTOO_DAT_VLD[vecs[v].ch]), 64'(vecs[v].exp_vld));
            chk("vec_add_b0", 64'(bus.DMX_MTOO_DAT_ADD[vecs[v].ch][0]), 64'(vecs[v].exp_add));
            chk("vec_add_b3", 64'(bus.DMX_MTOO_DAT_ADD[vecs[v].ch][3]), 64'(vecs[v].exp_add));
            chk("vec_dat", 64'(bus.DMX_MTOO_DAT_DAT[vecs[v].ch][2]), 64'(vecs[v].dat));
            chk("vec_lst", 64'(bus.DMX_MTOO_DAT_LST[vecs[v].ch][1]), 64'(vecs[v].lst));
            tmp = bus.DMX_MTOO_DAT_VLD;
            tmp[vecs[v].ch] = '0;
            chk("vec_other_ch", 64'(tmp), 64'h0);
            step();
            chk("vec_drained", 64'(bus.DMX_MTOO_DAT_VLD[vecs[v].ch]), 64'h0);
        end

        // Stall on bank 1 of ch0: slot holds, upstream stalls, then drains.
        bus.DMX_MTOO_DAT_RDY[0][1] = 1'b0;
        bus.MUX_MTOO_DAT_VLD[0] = 1'b1;
        bus.MUX_MTOO_DAT_ADD[0] = 12'h400;
        bus.MUX_MTOO_DAT_DAT[0] = 4'h7;
        step();
        bus.MUX_MTOO_DAT_ADD[0] = 12'h410;
        bus.MUX_MTOO_DAT_DAT[0] = 4'h2;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("stall_up_rdy", 64'(bus.MUX_MTOO_DAT_RDY[0]), 64'h0);
            chk("stall_vld", 64'(bus.DMX_MTOO_DAT_VLD[0]), 64'b0010);
            chk("stall_add", 64'(bus.DMX_MTOO_DAT_ADD[0][1]), 64'h000);
            chk("stall_dat", 64'(bus.DMX_MTOO_DAT_DAT[0][1]), 64'h7);
            step();
        end
        bus.DMX_MTOO_DAT_RDY[0][1] = 1'b1;
        #1;
        chk("stall_release_rdy", 64'(bus.MUX_MTOO_DAT_RDY[0]), 64'h1);
        step();
        bus.MUX_MTOO_DAT_VLD[0] = 1'b0;
        #1;
        chk("stall_next_vld", 64'(bus.DMX_MTOO_DAT_VLD[0]), 64'b0010);
        chk("stall_next_add", 64'(bus.DMX_MTOO_DAT_ADD[0][1]), 64'h010);
        chk("stall_next_dat", 64'(bus.DMX_MTOO_DAT_DAT[0][1]), 64'h2);
        step();
        chk("stall_drained", 64'(bus.DMX_MTOO_DAT_VLD[0]), 64'h0);

        // Ch1 in-order merge with out-of-order bank returns.
        bus.MUX_OTOM_DAT_RDY[1] = 1'b1;
        bus.MUX_MTOO_ADD_VLD[1] = 1'b1;
        bus.MUX_MTOO_ADD_ADD[1] = 12'h400;
        step();
        chk("rd1_out1", 64'(outstanding[1]), 64'h1);
        chk("rd1_addvld_b1", 64'(bus.DMX_MTOO_ADD_VLD[1]), 64'b0010);
        bus.MUX_MTOO_ADD_ADD[1] = 12'h800;
        step();
        bus.MUX_MTOO_ADD_VLD[1] = 1'b0;
        #1;
        chk("rd1_out2", 64'(outstanding[1]), 64'h2);
        chk("rd1_addvld_b2", 64'(bus.DMX_MTOO_ADD_VLD[1]), 64'b0100);
        bus.DMX_OTOM_DAT_VLD[1][2] = 1'b1;
        bus.DMX_OTOM_DAT_DAT[1][2] = 4'hA;
        #1;
        chk("rd1_b2_held_rdy", 64'(bus.DMX_OTOM_DAT_RDY[1]), 64'b0010);
        chk("rd1_up_vld_wait", 64'(bus.MUX_OTOM_DAT_VLD[1]), 64'h0);
        step();
        chk("rd1_out2_hold", 64'(outstanding[1]), 64'h2);
        bus.DMX_OTOM_DAT_VLD[1][1] = 1'b1;
        bus.DMX_OTOM_DAT_DAT[1][1] = 4'h5;
        #1;
        chk("rd1_first_vld", 64'(bus.MUX_OTOM_DAT_VLD[1]), 64'h1);
        chk("rd1_first_dat", 64'(bus.MUX_OTOM_DAT_DAT[1]), 64'h5);
        step();
        bus.DMX_OTOM_DAT_VLD[1][1] = 1'b0;
        #1;
        chk("rd1_out1_after", 64'(outstanding[1]), 64'h1);
        chk("rd1_second_vld", 64'(bus.MUX_OTOM_DAT_VLD[1]), 64'h1);
        chk("rd1_second_dat", 64'(bus.MUX_OTOM_DAT_DAT[1]), 64'hA);
        chk("rd1_b2_rdy", 64'(bus.DMX_OTOM_DAT_RDY[1]), 64'b0100);
        step();
        bus.DMX_OTOM_DAT_VLD[1][2] = 1'b0;
        #1;
        chk("rd1_out0", 64'(outstanding[1]), 64'h0);
        step();
        chk("rd1_no_err", 64'(err[1]), 64'h0);

        // Ch3 fills its tag FIFO; fifth request waits until a return frees a tag.
        bus.MUX_MTOO_ADD_VLD[3] = 1'b1;
        bus.MUX_MTOO_ADD_ADD[3] = 12'hC00;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("full_rdy_open", 64'(bus.MUX_MTOO_ADD_RDY[3]), 64'h1);
            step();
        end
        chk("full_out4", 64'(outstanding[3]), 64'h4);
        chk("full_rdy_closed", 64'(bus.MUX_MTOO_ADD_RDY[3]), 64'h0);
        step();
        chk("full_out4_hold", 64'(outstanding[3]), 64'h4);
        chk("full_rdy_closed2", 64'(bus.MUX_MTOO_ADD_RDY[3]), 64'h0);
        bus.MUX_OTOM_DAT_RDY[3] = 1'b1;
        bus.DMX_OTOM_DAT_VLD[3][3] = 1'b1;
        bus.DMX_OTOM_DAT_DAT[3][3] = 4'hC;
        #1;
        chk("full_ret_vld", 64'(bus.MUX_OTOM_DAT_VLD[3]), 64'h1);
        chk("full_rdy_no_bypass", 64'(bus.MUX_MTOO_ADD_RDY[3]), 64'h0);
        step();
        bus.DMX_OTOM_DAT_VLD[3][3] = 1'b0;
        #1;
        chk("full_out3", 64'(outstanding[3]), 64'h3);
        chk("full_rdy_reopen", 64'(bus.MUX_MTOO_ADD_RDY[3]), 64'h1);
        step();
        bus.MUX_MTOO_ADD_VLD[3] = 1'b0;
        #1;
        chk("full_out4_again", 64'(outstanding[3]), 64'h4);

        // Ch2 spurious return with nothing outstanding.
        bus.MUX_OTOM_DAT_RDY[2] = 1'b1;
        bus.DMX_OTOM_DAT_VLD[2][0] = 1'b1;
        #1;
        chk("spur_up_vld", 64'(bus.MUX_OTOM_DAT_VLD[2]), 64'h0);
        chk("spur_bank_rdy", 64'(bus.DMX_OTOM_DAT_RDY[2]), 64'h0);
        chk("spur_err_pre", 64'(err[2]), 64'h0);
        step();
        bus.DMX_OTOM_DAT_VLD[2][0] = 1'b0;
        #1;
        chk("spur_err_set", 64'(err[2]), 64'h1);
        step();
        chk("spur_err_sticky", 64'(err), 64'b0100);

        // Reset mid-burst on ch0: two reads outstanding and write slot stalled.
        bus.DMX_MTOO_DAT_RDY[0] = '0;
        bus.DMX_MTOO_ADD_RDY[0] = '0;
        bus.MUX_MTOO_ADD_VLD[0] = 1'b1;
        bus.MUX_MTOO_ADD_ADD[0] = 12'h100;
        bus.MUX_MTOO_DAT_VLD[0] = 1'b1;
        bus.MUX_MTOO_DAT_ADD[0] = 12'h200;
        bus.MUX_MTOO_DAT_DAT[0] = 4'hB;
        step();
        bus.MUX_MTOO_DAT_VLD[0] = 1'b0;
        bus.DMX_MTOO_ADD_RDY[0] = '1;
        step();
        bus.MUX_MTOO_ADD_VLD[0] = 1'b0;
        bus.DMX_MTOO_ADD_RDY[0] = '0;
        #1;
        chk("pre_rst_out", 64'(outstanding[0]), 64'h2);
        chk("pre_rst_wvld", 64'(bus.DMX_MTOO_DAT_VLD[0]), 64'b0001);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_wvld", 64'(bus.DMX_MTOO_DAT_VLD), 64'h0);
        chk("rst_async_rvld", 64'(bus.DMX_MTOO_ADD_VLD), 64'h0);
        chk("rst_async_out", 64'(outstanding), 64'h0);
        chk("rst_async_err", 64'(err), 64'h0);
        step();
        rst = 1'b0;
        bus.DMX_MTOO_DAT_RDY = '1;
        bus.DMX_MTOO_ADD_RDY = '1;
        bus.MUX_MTOO_DAT_VLD[0] = 1'b1;
        bus.MUX_MTOO_DAT_ADD[0] = 12'h123;
        bus.MUX_MTOO_DAT_DAT[0] = 4'h4;
        #1;
        chk("post_rst_rdy", 64'(bus.MUX_MTOO_DAT_RDY[0]), 64'h1);
        step();
        bus.MUX_MTOO_DAT_VLD[0] = 1'b0;
        #1;
        chk("post_rst_vld", 64'(bus.DMX_MTOO_DAT_VLD[0]), 64'b0001);
        chk("post_rst_add", 64'(bus.DMX_MTOO_DAT_ADD[0][0]), 64'h123);
        chk("post_rst_dat", 64'(bus.DMX_MTOO_DAT_DAT[0][0]), 64'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
